// File: rtl/mem_ctrl.sv
// Block-fill / block-writeback controller between a cache memory stage and a beat-wide memory port.
// Optional idle-cycle watchdog enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl #(
    parameter int BEAT_W  = 64,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cacheMiss,
    input  logic              cacheEvict,
    input  logic [31:0]       cacheAddr,
    input  logic [511:0]      mcDataOut,
    output logic [511:0]      mcDataIn,
    output logic              mcDataValid,
    output logic              evictDone,
    output logic              mcBusy,
    output logic              memReq,
    output logic              memWe,
    output logic [31:0]       memAddr,
    output logic              memWValid,
    output logic [BEAT_W-1:0] memWData,
    input  logic              memReady,
    input  logic              memRValid,
    input  logic [BEAT_W-1:0] memRData,
    output logic              mcError,
    output logic [2:0]        dbgState
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        WR_BEAT = 3'd2,
        WR_DONE = 3'd3,
        RD_CMD  = 3'd4,
        RD_BEAT = 3'd5,
        RD_DONE = 3'd6
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_beat;
    logic [511:0]       r_wblock;
    logic [511:0]       r_fill;
    logic [CNT_W-1:0]   w_beat_nxt;
    logic               w_last;
    logic               w_tmo_hit;
    logic               w_unused;

    assign w_beat_nxt = r_beat + 1'b1;
    assign w_last     = (r_beat == CNT_W'(BEATS - 1));
    assign dbgState   = r_state;
    // Byte offset inside the block never reaches memory; commands are block aligned.
    assign w_unused   = ^cacheAddr[5:0];

`ifdef MEM_CTRL_TIMEOUT_EN
    logic [7:0] r_tmo;
    logic       w_active;
    logic       w_hs;

    assign w_active  = (r_state == WR_CMD) || (r_state == WR_BEAT) ||
                       (r_state == RD_CMD) || (r_state == RD_BEAT);
    assign w_hs      = (r_state == RD_BEAT) ? memRValid : memReady;
    assign w_tmo_hit = w_active && !w_hs && (r_tmo == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo   <= '0;
            mcError <= 1'b0;
        end else begin
            if (!w_active || w_hs) r_tmo <= '0;
            else                   r_tmo <= r_tmo + 8'd1;
            if (w_tmo_hit)         mcError <= 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign mcError   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_wblock    <= '0;
            r_fill      <= '0;
            mcDataIn    <= '0;
            mcDataValid <= 1'b0;
            evictDone   <= 1'b0;
            mcBusy      <= 1'b0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWValid   <= 1'b0;
            memWData    <= '0;
        end else begin
            mcDataValid <= 1'b0;
            evictDone   <= 1'b0;
            if (w_tmo_hit) begin
                r_state   <= IDLE;
                r_beat    <= '0;
                mcBusy    <= 1'b0;
                memReq    <= 1'b0;
                memWe     <= 1'b0;
                memAddr   <= '0;
                memWValid <= 1'b0;
                memWData  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cacheEvict) begin
                            r_wblock <= mcDataOut;
                            memAddr  <= {cacheAddr[31:6], 6'b0};
                            memReq   <= 1'b1;
                            memWe    <= 1'b1;
                            mcBusy   <= 1'b1;
                            r_state  <= WR_CMD;
                        end else if (cacheMiss) begin
                            memAddr  <= {cacheAddr[31:6], 6'b0};
                            memReq   <= 1'b1;
                            memWe    <= 1'b0;
                            mcBusy   <= 1'b1;
                            r_state  <= RD_CMD;
                        end
                    end
                    WR_CMD: begin
                        if (memReady) begin
                            memReq    <= 1'b0;
                            memWe     <= 1'b0;
                            memWValid <= 1'b1;
                            memWData  <= r_wblock[BEAT_W-1:0];
                            r_beat    <= '0;
                            r_state   <= WR_BEAT;
                        end
                    end
                    WR_BEAT: begin
                        if (memReady) begin
                            if (w_last) begin
                                memWValid <= 1'b0;
                                memWData  <= '0;
                                r_beat    <= '0;
                                evictDone <= 1'b1;
                                r_state   <= WR_DONE;
                            end else begin
                                r_beat    <= w_beat_nxt;
                                memWData  <= r_wblock[BEAT_W*w_beat_nxt +: BEAT_W];
                            end
                        end
                    end
                    WR_DONE: begin
                        mcBusy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    RD_CMD: begin
                        if (memReady) begin
                            memReq  <= 1'b0;
                            r_beat  <= '0;
                            r_state <= RD_BEAT;
                        end
                    end
                    RD_BEAT: begin
                        if (memRValid) begin
                            r_fill[BEAT_W*r_beat +: BEAT_W] <= memRData;
                            if (w_last) begin
                                // Output copy updates only on a completed block so partial fills stay invisible.
                                mcDataIn    <= {memRData, r_fill[BEAT_W*(BEATS-1)-1:0]};
                                mcDataValid <= 1'b1;
                                r_beat      <= '0;
                                r_state     <= RD_DONE;
                            end else begin
                                r_beat <= w_beat_nxt;
                            end
                        end
                    end
                    RD_DONE: begin
                        mcBusy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: random memory responder, expected queues filled by the stimulus,
// and a negedge monitor that pops and compares on every DUT handshake or completion pulse.
module tb_mem_ctrl;
    localparam int BW = 64;
    localparam int NB = 8;
    localparam logic [31:0] BLK_MASK = 32'hFFFF_FFC0;

    logic          clk = 1'b0;
    logic          rst;
    logic          cacheMiss, cacheEvict;
    logic [31:0]   cacheAddr;
    logic [511:0]  mcDataOut, mcDataIn;
    logic          mcDataValid, evictDone, mcBusy, memReq, memWe;
    logic [31:0]   memAddr;
    logic          memWValid;
    logic [BW-1:0] memWData;
    logic          memReady, memRValid;
    logic [BW-1:0] memRData;
    logic          mcError;
    logic [2:0]    dbgState;

    mem_ctrl #(.BEAT_W(BW), .BEATS(NB), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .cacheMiss(cacheMiss), .cacheEvict(cacheEvict),
        .cacheAddr(cacheAddr), .mcDataOut(mcDataOut), .mcDataIn(mcDataIn),
        .mcDataValid(mcDataValid), .evictDone(evictDone), .mcBusy(mcBusy),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWValid(memWValid),
        .memWData(memWData), .memReady(memReady), .memRValid(memRValid),
        .memRData(memRData), .mcError(mcError), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [32:0]   exp_cmd_q[$];
    logic [BW-1:0] exp_wbeat_q[$];
    logic [511:0]  exp_fill_q[$];
    logic [BW-1:0] rd_data_q[$];
    int            exp_evict_n = 0;
    int            wbeat_n = 0;
    int            last_wbeat_cyc = 0;
    int            beats_sent = 0;
    int            ready_pct = 100;
    int            stall_left = 0;
    bit            rd_active = 1'b0;
    bit            stray_en = 1'b0;
    bit            stall_mode = 1'b0;
    logic [511:0]  last_fill = '0;
    logic          prev_wv = 1'b0, prev_rdy = 1'b0;
    logic [BW-1:0] prev_wd = '0;
    logic [32:0]   mon_cmd;
    logic [BW-1:0] mon_beat;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [511:0] act);
        checks++;
        errors++;
        $display("FAIL %s: DUT presented %0h with nothing expected", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Memory responder: random ready, gapped read beats, optional stray read beats.
    initial begin
        memReady = 1'b0; memRValid = 1'b0; memRData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                memReady = 1'b0; memRValid = 1'b0;
            end else begin
                if (stall_mode && (wbeat_n % NB) == 2 && stall_left > 0) begin
                    memReady = 1'b0;
                    stall_left--;
                end else begin
                    memReady = ($urandom_range(99) < ready_pct);
                end
                if (rd_active && rd_data_q.size() > 0 && !memRValid && $urandom_range(1) == 1) begin
                    memRValid = 1'b1;
                    memRData  = rd_data_q.pop_front();
                    beats_sent++;
                    if (rd_data_q.size() == 0) rd_active = 1'b0;
                end else begin
                    memRValid = stray_en && !rd_active && ($urandom_range(3) == 0);
                    memRData  = {$urandom, $urandom};
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_wv = 1'b0;
        end else begin
            if (memReq && memReady) begin
                if (exp_cmd_q.size() == 0) unexpected("mem_cmd", {memWe, memAddr});
                else begin
                    mon_cmd = exp_cmd_q.pop_front();
                    chk("mem_cmd", {memWe, memAddr}, mon_cmd);
                    if (!mon_cmd[32]) rd_active = 1'b1;
                end
            end
            if (memWValid && memReady) begin
                if (exp_wbeat_q.size() == 0) unexpected("wr_beat", memWData);
                else begin
                    mon_beat = exp_wbeat_q.pop_front();
                    chk($sformatf("wr_beat%0d", wbeat_n % NB), memWData, mon_beat);
                end
                wbeat_n++;
                if ((wbeat_n % NB) == 0) last_wbeat_cyc = cyc;
            end
            if (prev_wv && !prev_rdy && memWValid) chk("wdata_hold", memWData, prev_wd);
            prev_wv = memWValid; prev_rdy = memReady; prev_wd = memWData;
            if (evictDone) begin
                if (exp_evict_n == 0) unexpected("evict_done", 512'(1));
                else begin
                    exp_evict_n--;
                    chk("evict_done_lat", 512'(cyc - last_wbeat_cyc), 512'(1));
                end
            end
            if (mcDataValid) begin
                if (exp_fill_q.size() == 0) unexpected("fill_data", mcDataIn);
                else begin
                    last_fill = exp_fill_q.pop_front();
                    chk("fill_data", mcDataIn, last_fill);
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_cmd_q.size() != 0 || exp_wbeat_q.size() != 0 || exp_fill_q.size() != 0 ||
                exp_evict_n != 0 || mcBusy) && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
        chk($sformatf("%s_idle", name), 512'(mcBusy), 512'(0));
        chk($sformatf("%s_data_hold", name), mcDataIn, last_fill);
    endtask

    // kind 0 = evict, 1 = fill, 2 = evict and miss together.
    task automatic do_txn(input string name, input int kind, input logic [31:0] addr_a,
                          input logic [511:0] blk, input logic [31:0] addr_b,
                          input logic [511:0] fill_blk);
        int n;
        logic [31:0] fa;
        fa = (kind == 1) ? addr_a : addr_b;
        if (kind != 1) begin
            exp_cmd_q.push_back({1'b1, addr_a & BLK_MASK});
            for (int k = 0; k < NB; k++) exp_wbeat_q.push_back(blk[BW*k +: BW]);
            exp_evict_n++;
        end
        if (kind != 0) begin
            exp_cmd_q.push_back({1'b0, fa & BLK_MASK});
            for (int k = 0; k < NB; k++) rd_data_q.push_back(fill_blk[BW*k +: BW]);
            exp_fill_q.push_back(fill_blk);
        end
        cacheAddr = addr_a; mcDataOut = blk;
        cacheEvict = (kind != 1); cacheMiss = (kind != 0);
        n = 0;
        while (!mcBusy && n < 50) begin step(); n++; end
        chk($sformatf("%s_accepted", name), 512'(mcBusy), 512'(1));
        cacheEvict = 1'b0;
        if (kind == 1) cacheMiss = 1'b0;
        cacheAddr = (kind == 2) ? addr_b : $urandom;
        mcDataOut = rand512();
        if (kind == 2) begin
            n = 0;
            while (exp_cmd_q.size() > 0 && n < 1000) begin step(); n++; end
            cacheMiss = 1'b0;
        end
        wait_done(name);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] blk, fblk;
        int n, base;
        rst = 1'b1; cacheMiss = 1'b0; cacheEvict = 1'b0; cacheAddr = '0; mcDataOut = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset_ctrl", 512'({mcDataValid, evictDone, mcBusy, memReq, memWe, memWValid, mcError}), 512'(0));
        chk("reset_memAddr", 512'(memAddr), 512'(0));
        chk("reset_memWData", 512'(memWData), 512'(0));
        chk("reset_mcDataIn", mcDataIn, 512'(0));
        chk("reset_state", 512'(dbgState), 512'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Directed evict: beat k = 0x1111..11 * k.
        ready_pct = 100;
        for (int k = 0; k < NB; k++) blk[BW*k +: BW] = 64'h1111_1111_1111_1111 * 64'(k);
        do_txn("evict_dir", 0, 32'h0000_1234, blk, '0, '0);

        // Directed fill with gapped beats 0xA0..0xA7.
        for (int k = 0; k < NB; k++) fblk[BW*k +: BW] = 64'hA0 + 64'(k);
        do_txn("fill_dir", 1, 32'h0000_2040, '0, '0, fblk);
        chk("fill_dir_low", 512'(mcDataIn[63:0]), 512'(64'hA0));
        chk("fill_dir_high", 512'(mcDataIn[511:448]), 512'(64'hA7));

        // Evict and miss together: write completes first, then the read.
        do_txn("both_dir", 2, 32'h0001_0080, rand512(), 32'h0002_00C4, rand512());

        // Three-cycle stall on write beat 2.
        stall_mode = 1'b1; stall_left = 3;
        do_txn("stall_dir", 0, 32'h0003_0000, rand512(), '0, '0);
        chk("stall_applied", 512'(stall_left), 512'(0));
        stall_mode = 1'b0;

        // Reset in the middle of a read burst.
        fblk = rand512();
        for (int k = 0; k < NB; k++) rd_data_q.push_back(fblk[BW*k +: BW]);
        exp_cmd_q.push_back({1'b0, 32'h0000_3000});
        cacheAddr = 32'h0000_3010; cacheMiss = 1'b1; base = beats_sent;
        n = 0;
        while (!mcBusy && n < 50) begin step(); n++; end
        cacheMiss = 1'b0;
        n = 0;
        while (beats_sent - base < 4 && n < 200) begin @(posedge clk); #2; n++; end
        chk("rst_mid_reached", 512'(beats_sent - base >= 4), 512'(1));
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", 512'({mcDataValid, evictDone, mcBusy, memReq, memWe, memWValid, mcError}), 512'(0));
        chk("rst_mid_memAddr", 512'(memAddr), 512'(0));
        chk("rst_mid_memWData", 512'(memWData), 512'(0));
        chk("rst_mid_mcDataIn", mcDataIn, 512'(0));
        chk("rst_mid_state", 512'(dbgState), 512'(0));
        last_fill = '0;
        rd_data_q.delete(); exp_cmd_q.delete(); rd_active = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        do_txn("fill_after_rst", 1, 32'h0000_4080, '0, '0, rand512());

        // Random traffic with random backpressure and stray read beats.
        stray_en = 1'b1;
        for (int t = 0; t < 25; t++) begin
            ready_pct = $urandom_range(100, 30);
            do_txn($sformatf("rand%0d", t), $urandom_range(2), $urandom, rand512(), $urandom, rand512());
        end
        stray_en = 1'b0;
        ready_pct = 100;

`ifdef MEM_CTRL_TIMEOUT_EN
        // Memory never accepts the read command.
        ready_pct = 0;
        cacheAddr = 32'h0000_5000; cacheMiss = 1'b1;
        n = 0;
        while (!mcBusy && n < 50) begin step(); n++; end
        cacheMiss = 1'b0;
        repeat (250) step();
        chk("tmo_before_err", 512'(mcError), 512'(0));
        chk("tmo_before_busy", 512'(mcBusy), 512'(1));
        repeat (10) step();
        chk("tmo_err", 512'(mcError), 512'(1));
        chk("tmo_idle", 512'(mcBusy), 512'(0));
        chk("tmo_state", 512'(dbgState), 512'(0));
        ready_pct = 100;
        chk("final_mcError", 512'(mcError), 512'(1));
`else
        chk("final_mcError", 512'(mcError), 512'(0));
`endif
        chk("final_queues", 512'(exp_cmd_q.size() + exp_wbeat_q.size() + exp_fill_q.size() + exp_evict_n), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
